// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad scanner state encoding, column reset
// pattern and the 4x4 key code table (Pmod KYPD layout).
package calc_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } scan_state_e;

    localparam logic [3:0] COL_RST = 4'b1110;

    // Indexed by {row, col}; entry 0 sits in the least-significant nibble.
    localparam logic [63:0] KEY_TABLE = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_TABLE[{row, col, 2'b00} +: 4];
    endfunction

    function automatic logic [1:0] lowest_low_row(input logic [3:0] row);
        if (!row[0])      return 2'd0;
        else if (!row[1]) return 2'd1;
        else if (!row[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] col);
        case (col)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running column dwell counter; tick is high on the last cycle of each
// 2^SCAN_DIV_W-cycle dwell.
module scan_tick_gen #(
    parameter int SCAN_DIV_W = 17
) (
    input  logic Clk,
    input  logic Reset,
    output logic tick
);

    logic [SCAN_DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + {{(SCAN_DIV_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge Clk) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, hex key code and valid strobe.
// Optional auto-repeat while held when KEYPAD_REPEAT_EN is defined. DEB_CNT >= 2.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV_W = 17,
    parameter int DEB_CNT    = 4
`ifdef KEYPAD_REPEAT_EN
    , parameter int REPEAT_TICKS = 256
`endif
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Row,
    output logic [3:0] Col,
    output logic [3:0] Key,
    output logic       KeyValid,
    output logic       KeyHeld
);

    localparam int DEB_W = $clog2(DEB_CNT + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    logic              tick;
    scan_state_e       state_q, state_d;
    logic [3:0]        row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [3:0]        col_q, col_d, key_q, key_d;
    logic              key_valid_q, key_valid_d, key_held_q, key_held_d;
    logic [1:0]        cand_row_q, cand_row_d, cand_col_q, cand_col_d;
    logic [DEB_W-1:0]  deb_q, deb_d, rel_q, rel_d;
    logic              cand_low;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
    logic [RPT_W-1:0]  rpt_q, rpt_d;
`endif

    scan_tick_gen #(.SCAN_DIV_W(SCAN_DIV_W)) u_tick (
        .Clk   (Clk),
        .Reset (Reset),
        .tick  (tick)
    );

    assign cand_low = ~row_s2_q[cand_row_q];

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        row_s1_d    = Row;
        row_s2_d    = row_s1_q;
        col_d       = col_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        deb_d       = deb_q;
        rel_d       = rel_q;
`ifdef KEYPAD_REPEAT_EN
        rpt_d       = rpt_q;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (&row_s2_q) begin
                        col_d = {col_q[2:0], col_q[3]};
                    end else begin
                        cand_row_d = lowest_low_row(row_s2_q);
                        cand_col_d = col_index(col_q);
                        deb_d      = DEB_ONE;
                        state_d    = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!cand_low) begin
                        deb_d   = '0;
                        col_d   = {col_q[2:0], col_q[3]};
                        state_d = ST_SCAN;
                    end else if (deb_q == DEB_LAST) begin
                        key_d       = key_code(cand_row_q, cand_col_q);
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        deb_d       = '0;
                        rel_d       = '0;
                        state_d     = ST_HELD;
                    end else begin
                        deb_d = deb_q + DEB_ONE;
                    end
                end
                ST_HELD: begin
                    if (cand_low) begin
                        rel_d = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rpt_q == RPT_W'(REPEAT_TICKS - 1)) begin
                            key_valid_d = 1'b1;
                            rpt_d       = '0;
                        end else begin
                            rpt_d = rpt_q + RPT_W'(1);
                        end
`endif
                    end else if (rel_q == DEB_LAST) begin
                        key_held_d = 1'b0;
                        rel_d      = '0;
                        col_d      = {col_q[2:0], col_q[3]};
                        state_d    = ST_SCAN;
`ifdef KEYPAD_REPEAT_EN
                        rpt_d      = '0;
`endif
                    end else begin
                        rel_d = rel_q + DEB_ONE;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_SCAN;
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            col_q       <= COL_RST;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            cand_row_q  <= '0;
            cand_col_q  <= '0;
            deb_q       <= '0;
            rel_q       <= '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            col_q       <= col_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            deb_q       <= deb_d;
            rel_q       <= rel_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= rpt_d;
`endif
        end
    end

    assign Col      = col_q;
    assign Key      = key_q;
    assign KeyValid = key_valid_q;
    assign KeyHeld  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model, directed scenarios and
// random multi-row presses checked against a key-map reference.
module tb_keypad_scanner;

    localparam int DWELL = 16;
    localparam int DEB   = 3;
`ifdef KEYPAD_REPEAT_EN
    localparam int RPT   = 8;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] Row, Col, Key;
    logic       KeyValid, KeyHeld;
    logic [15:0] press;

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;
    logic [3:0] last_key = '0;

    int keymap [4][4] = '{'{1, 2, 3, 'hA},
                          '{4, 5, 6, 'hB},
                          '{7, 8, 9, 'hC},
                          '{0, 'hF, 'hE, 'hD}};

    always #5 Clk = ~Clk;

    // Keypad: a row reads low when a pressed key in that row sits on a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) Row[r] = ~|(press[r*4 +: 4] & ~Col);
    end

    keypad_scanner #(
        .SCAN_DIV_W (4),
        .DEB_CNT    (DEB)
`ifdef KEYPAD_REPEAT_EN
        , .REPEAT_TICKS (RPT)
`endif
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Row      (Row),
        .Col      (Col),
        .Key      (Key),
        .KeyValid (KeyValid),
        .KeyHeld  (KeyHeld)
    );

    always @(negedge Clk) begin
        if (KeyValid === 1'b1) begin
            strobe_cnt++;
            last_key = Key;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    function automatic int expect_code(input logic [15:0] p, input int c);
        for (int r = 0; r < 4; r++) if (p[r*4 + c]) return keymap[r][c];
        return -1;
    endfunction

    task automatic press_key(input int r, input int c);
        press[r*4 + c] = 1'b1;
    endtask

    task automatic wait_strobe(input int prev, input string tag);
        int n = 0;
        while (strobe_cnt == prev && n < 400) begin cyc(1); n++; end
        check({tag, "_strobe_timeout"}, 32'(strobe_cnt != prev), 32'd1);
    endtask

    task automatic wait_release(input string tag);
        int n = 0;
        while (KeyHeld !== 1'b0 && n < 400) begin cyc(1); n++; end
        check({tag, "_release_timeout"}, 32'(KeyHeld === 1'b0), 32'd1);
    endtask

    task automatic wait_col(input logic [3:0] target, input string tag);
        int n = 0;
        while (Col === target && n < 100) begin cyc(1); n++; end
        while (Col !== target && n < 200) begin cyc(1); n++; end
        check({tag, "_col_timeout"}, 32'(Col === target), 32'd1);
    endtask

    initial begin
        int s, s1, exp_code, c;
        logic [3:0] m;

        Reset = 1'b1;
        press = '0;
        cyc(3);
        check("rst_col", 32'(Col), 32'hE);
        check("rst_key", 32'(Key), 32'h0);
        check("rst_valid", 32'(KeyValid), 32'h0);
        check("rst_held", 32'(KeyHeld), 32'h0);

        // 1: idle rotation at 16-cycle steps
        Reset = 1'b0;
        cyc(15);
        check("rot_hold", 32'(Col), 32'b1110);
        cyc(1);
        check("rot_1", 32'(Col), 32'b1101);
        cyc(DWELL);
        check("rot_2", 32'(Col), 32'b1011);
        cyc(DWELL);
        check("rot_3", 32'(Col), 32'b0111);
        cyc(DWELL);
        check("rot_wrap", 32'(Col), 32'b1110);
        check("idle_no_strobe", 32'(strobe_cnt), 32'd0);

        // 2: key 5 pressed; column 1 at edge 80, capture 96, accept on tick 128
        press_key(1, 1);
        cyc(63);
        check("k5_before", 32'(KeyValid), 32'd0);
        cyc(1);
        check("k5_valid", 32'(KeyValid), 32'd1);
        check("k5_key", 32'(Key), 32'h5);
        check("k5_held", 32'(KeyHeld), 32'd1);
        cyc(1);
        check("k5_pulse_end", 32'(KeyValid), 32'd0);
        cyc(3 * DWELL);
        check("k5_col_frozen", 32'(Col), 32'b1101);
        check("k5_one_strobe", 32'(strobe_cnt), 32'd1);

        // 5: release key 5, then key 0
        press = '0;
        wait_release("k5");
        check("k5_rel_col", 32'(Col), 32'b1011);
        s = strobe_cnt;
        press_key(3, 0);
        wait_strobe(s, "k0");
        check("k0_key", 32'(Key), 32'(keymap[3][0]));
        check("k0_last", 32'(last_key), 32'(keymap[3][0]));
        press = '0;
        wait_release("k0");
        check("k0_strobes", 32'(strobe_cnt), 32'(s + 1));

        // 3: one-tick glitch on row 0 / column 3
        s = strobe_cnt;
        wait_col(4'b0111, "glitch");
        cyc(10);
        press_key(0, 3);
        cyc(10);
        press = '0;
        cyc(11);
        check("glitch_frozen", 32'(Col), 32'b0111);
        cyc(1);
        check("glitch_resume", 32'(Col), 32'b1110);
        check("glitch_no_strobe", 32'(strobe_cnt), 32'(s));
        check("glitch_not_held", 32'(KeyHeld), 32'd0);

        // 4: rows 0 and 2 on column 2, lowest row wins
        s = strobe_cnt;
        press_key(0, 2);
        press_key(2, 2);
        exp_code = expect_code(press, 2);
        wait_strobe(s, "multi");
        check("multi_key", 32'(Key), 32'(exp_code));
        press = '0;
        wait_release("multi");

        // 6: reset while held
        s = strobe_cnt;
        press_key(2, 2);
        wait_strobe(s, "rst_held");
        check("pre_rst_held", 32'(KeyHeld), 32'd1);
        Reset = 1'b1;
        cyc(1);
        check("midrst_col", 32'(Col), 32'b1110);
        check("midrst_key", 32'(Key), 32'h0);
        check("midrst_held", 32'(KeyHeld), 32'd0);
        check("midrst_valid", 32'(KeyValid), 32'd0);
        press = '0;
        s = strobe_cnt;
        cyc(2);
        Reset = 1'b0;
        cyc(5);
        check("midrst_no_strobe", 32'(strobe_cnt), 32'(s));

        // 7: long hold of key E
        s = strobe_cnt;
        press_key(3, 2);
        wait_strobe(s, "kE");
        check("kE_first", 32'(last_key), 32'hE);
        s1 = strobe_cnt;
        cyc(400);
`ifdef KEYPAD_REPEAT_EN
        check("kE_repeats", 32'(strobe_cnt - s1), 32'(400 / (DWELL * RPT)));
`else
        check("kE_repeats", 32'(strobe_cnt - s1), 32'd0);
`endif
        check("kE_last", 32'(last_key), 32'hE);
        press = '0;
        wait_release("kE");

        // Random presses, possibly several rows in one column
        for (int i = 0; i < 8; i++) begin
            c = int'($urandom_range(0, 3));
            m = 4'($urandom_range(1, 15));
            press = '0;
            for (int r = 0; r < 4; r++) if (m[r]) press_key(r, c);
            exp_code = expect_code(press, c);
            s = strobe_cnt;
            wait_strobe(s, "rnd");
            check("rnd_key", 32'(Key), 32'(exp_code));
            check("rnd_held", 32'(KeyHeld), 32'd1);
            press = '0;
            wait_release("rnd");
            check("rnd_one_strobe", 32'(strobe_cnt), 32'(s + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
